// File: rtl/controller_top.sv
// Two paged burst memory controllers on one shared multiplexed address/data bus.
// Latency: 4-word bursts follow the accept edge back-to-back. No backpressure; strobes during a burst are ignored.
module mem_ctrl #(
    parameter int DATAWIDTH  = 16,
    parameter int ADDRWIDTH  = 16,
    parameter int DATABURST  = 4,
    parameter int PAGEBITS   = 4,
    parameter int OFFSETBITS = 12,
    parameter logic [PAGEBITS-1:0] PAGE = 4'h2
) (
    input  logic                 clk,
    input  logic                 resetL,
    input  logic [DATAWIDTH-1:0] bus_i,
    input  logic                 addr_valid_i,
    input  logic                 rw_i,
    output logic [DATAWIDTH-1:0] rd_dat_o,
    output logic                 rd_en_o
);
    localparam int CW = $clog2(DATABURST) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DATAWIDTH-1:0]   mem [2**OFFSETBITS];
    logic [OFFSETBITS-1:0]  idx;
    logic [DATAWIDTH-1:0]   DataMem;
    logic                   ReadEnable, WriteEnable;
    logic                   accept, last;

    assign accept = addr_valid_i && (bus_i[DATAWIDTH-1 -: PAGEBITS] == PAGE);
    assign last   = (count_q == CW'(DATABURST - 1));
    // Offset arithmetic is truncated to the offset width so bursts wrap inside the page.
    assign idx    = addr_q[OFFSETBITS-1:0] + OFFSETBITS'(count_q);

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            state_q <= IDLE;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = rw_i ? READ : WRITE;
                    addr_d  = bus_i;
                    count_d = '0;
                end
            end
            WRITE, READ: begin
                count_d = count_q + CW'(1);
                if (last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ReadEnable  = (state_q == READ);
        WriteEnable = (state_q == WRITE);
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (WriteEnable) mem[idx] <= bus_i;
    end

    assign DataMem  = mem[idx];
    assign rd_dat_o = DataMem;
    assign rd_en_o  = ReadEnable;
endmodule

module controller_top #(
    parameter int DATAWIDTH  = 16,
    parameter int ADDRWIDTH  = 16,
    parameter int DATABURST  = 4,
    parameter int PAGEBITS   = 4,
    parameter logic [PAGEBITS-1:0] PAGE1 = 4'h2,
    parameter logic [PAGEBITS-1:0] PAGE2 = 4'h8,
    parameter int OFFSETBITS = 12
) (
    input  logic                 clk,
    input  logic                 resetL,
    inout  wire  [DATAWIDTH-1:0] AddrData,
    input  logic                 AddrValid,
    input  logic                 rw
);
    logic [DATAWIDTH-1:0] rd_dat1, rd_dat2;
    logic                 rd_en1, rd_en2;

    mem_ctrl #(
        .DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH), .DATABURST(DATABURST),
        .PAGEBITS(PAGEBITS), .OFFSETBITS(OFFSETBITS), .PAGE(PAGE1)
    ) u_inst1 (
        .clk(clk), .resetL(resetL), .bus_i(AddrData), .addr_valid_i(AddrValid),
        .rw_i(rw), .rd_dat_o(rd_dat1), .rd_en_o(rd_en1)
    );

    mem_ctrl #(
        .DATAWIDTH(DATAWIDTH), .ADDRWIDTH(ADDRWIDTH), .DATABURST(DATABURST),
        .PAGEBITS(PAGEBITS), .OFFSETBITS(OFFSETBITS), .PAGE(PAGE2)
    ) u_inst2 (
        .clk(clk), .resetL(resetL), .bus_i(AddrData), .addr_valid_i(AddrValid),
        .rw_i(rw), .rd_dat_o(rd_dat2), .rd_en_o(rd_en2)
    );

    // Pages are disjoint, so at most one instance is ever in READ.
    assign AddrData = rd_en1 ? rd_dat1 : (rd_en2 ? rd_dat2 : {DATAWIDTH{1'bz}});
endmodule

// File: tb/tb_controller_top.sv
// Bench for controller_top: table of directed transactions, corner sequences, then random traffic against a memory model.
module tb_controller_top;
    logic        clk = 1'b0;
    logic        resetL = 1'b0;
    logic        AddrValid = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] tb_dat = '0;
    logic        tb_en = 1'b0;
    wire  [15:0] AddrData;

    assign AddrData = tb_en ? tb_dat : 16'bz;
    always #5 clk = ~clk;

    controller_top dut (
        .clk(clk), .resetL(resetL), .AddrData(AddrData), .AddrValid(AddrValid), .rw(rw)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference storage: instance index 0 = page 2, 1 = page 8.
    logic [15:0] ref_mem [2][4096];
    bit          ref_vld [2][4096];

    typedef struct {
        bit               rd;
        logic [15:0]      addr;
        logic [3:0][15:0] dat;
        int               inst;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] ren();
        return {dut.u_inst2.ReadEnable, dut.u_inst1.ReadEnable};
    endfunction
    function automatic logic [1:0] wen();
        return {dut.u_inst2.WriteEnable, dut.u_inst1.WriteEnable};
    endfunction
    function automatic logic [3:0] states();
        return {dut.u_inst2.state_q, dut.u_inst1.state_q};
    endfunction
    function automatic logic [1:0] onehot(input int inst);
        return (inst == 1) ? 2'b01 : (inst == 2) ? 2'b10 : 2'b00;
    endfunction
    function automatic int inst_of(input logic [15:0] a);
        return (a[15:12] == 4'h2) ? 1 : (a[15:12] == 4'h8) ? 2 : 0;
    endfunction
    function automatic logic [3:0][15:0] mk(input logic [15:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic check_reset(input string nm);
        chk({nm, "_state"}, states(), 4'h0);
        chk({nm, "_count"}, {dut.u_inst2.count_q, dut.u_inst1.count_q}, 6'd0);
        chk({nm, "_ren"}, ren(), 2'b00);
    endtask

    // Entered and left at a falling edge; the bus stays driven with the last word afterwards.
    task automatic do_write(input logic [15:0] a, input logic [3:0][15:0] d, input int inst,
                            input int reset_k, input string nm);
        int idx;
        tb_en = 1'b1; tb_dat = a; AddrValid = 1'b1; rw = 1'b0;
        @(negedge clk);
        AddrValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tb_dat = d[k];
            if (k == reset_k) begin
                resetL = 1'b0;
                #1;
                check_reset({nm, "_wrst"});
                @(negedge clk);
                resetL = 1'b1;
                return;
            end
            chk({nm, "_wr_ren"}, ren(), 2'b00);
            chk({nm, "_wr_wen"}, wen(), onehot(inst));
            if (inst != 0) begin
                idx = (int'(a[11:0]) + k) % 4096;
                ref_mem[inst-1][idx] = d[k];
                ref_vld[inst-1][idx] = 1'b1;
            end
            @(negedge clk);
        end
        chk({nm, "_wr_idle"}, states(), 4'h0);
    endtask

    // use_tbl selects the caller's expected words; otherwise the model supplies them.
    task automatic do_read(input logic [15:0] a, input logic [3:0][15:0] exp, input bit use_tbl,
                           input int inst, input int strobe_k, input int reset_k, input string nm);
        int idx;
        tb_en = 1'b1; tb_dat = a; AddrValid = 1'b1; rw = 1'b1;
        @(posedge clk);
        #1;
        tb_en = 1'b0; AddrValid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            AddrValid = (k == strobe_k);
            if (k == strobe_k) rw = 1'($urandom_range(0, 1));
            if (k == reset_k) begin
                resetL = 1'b0;
                #1;
                check_reset({nm, "_rrst"});
                @(negedge clk);
                resetL = 1'b1;
                AddrValid = 1'b0;
                return;
            end
            chk({nm, "_rd_ren"}, ren(), onehot(inst));
            if (inst != 0) begin
                idx = (int'(a[11:0]) + k) % 4096;
                if (use_tbl)
                    chk({nm, "_rd_dat"}, AddrData, exp[k]);
                else if (ref_vld[inst-1][idx])
                    chk({nm, "_rd_dat"}, AddrData, ref_mem[inst-1][idx]);
            end
            @(negedge clk);
        end
        AddrValid = 1'b0;
        chk({nm, "_rd_release"}, ren(), 2'b00);
        chk({nm, "_rd_idle"}, states(), 4'h0);
    endtask

    vec_t vecs [8];

    initial begin
        logic [15:0] a;
        logic [3:0][15:0] d;
        int pg, off, inst;

        vecs[0] = '{1'b0, 16'h200A, mk(16'd55, 16'd255, 16'd128, 16'd17), 1};
        vecs[1] = '{1'b1, 16'h200A, mk(16'd55, 16'd255, 16'd128, 16'd17), 1};
        vecs[2] = '{1'b1, 16'h000A, mk(16'h0, 16'h0, 16'h0, 16'h0), 0};
        vecs[3] = '{1'b0, 16'h20F0, mk(16'hFFFF, 16'hF0F0, 16'h0F0F, 16'hFF00), 1};
        vecs[4] = '{1'b1, 16'h20F0, mk(16'hFFFF, 16'hF0F0, 16'h0F0F, 16'hFF00), 1};
        vecs[5] = '{1'b0, 16'h80F0, mk(16'h0101, 16'h1010, 16'h0110, 16'h1001), 2};
        vecs[6] = '{1'b1, 16'h80F0, mk(16'h0101, 16'h1010, 16'h0110, 16'h1001), 2};
        vecs[7] = '{1'b1, 16'h20F0, mk(16'hFFFF, 16'hF0F0, 16'h0F0F, 16'hFF00), 1};

        #12;
        check_reset("reset");
        @(negedge clk);
        resetL = 1'b1;
        @(negedge clk);

        // Directed transactions run back-to-back with no idle cycle between them.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rd)
                do_read(vecs[i].addr, vecs[i].dat, 1'b1, vecs[i].inst, -1, -1, $sformatf("vec%0d", i));
            else
                do_write(vecs[i].addr, vecs[i].dat, vecs[i].inst, -1, $sformatf("vec%0d", i));
        end

        do_read(16'h20F0, mk(16'hFFFF, 16'hF0F0, 16'h0F0F, 16'hFF00), 1'b1, 1, 1, -1, "strobe");
        do_read(16'h20F0, mk(16'hFFFF, 16'hF0F0, 16'h0F0F, 16'hFF00), 1'b1, 1, -1, 2, "rdreset");
        do_read(16'h20F0, mk(16'hFFFF, 16'hF0F0, 16'h0F0F, 16'hFF00), 1'b1, 1, -1, -1, "after_rst");

        do_write(16'h2100, mk(16'h1111, 16'h2222, 16'h3333, 16'h4444), 1, -1, "wpre");
        do_write(16'h2100, mk(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD), 1, 2, "wrreset");
        do_read(16'h2100, mk(16'hAAAA, 16'hBBBB, 16'h3333, 16'h4444), 1'b1, 1, -1, -1, "wrkeep");

        do_write(16'h8FFE, mk(16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04), 2, -1, "wrap");
        do_read(16'h8000, mk(16'h5A03, 16'h5A04, 16'h0, 16'h0), 1'b0, 2, -1, -1, "wrap_rd");

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0, 1: pg = 2;
                2, 3: pg = 8;
                default: begin
                    pg = $urandom_range(0, 15);
                    if (pg == 2 || pg == 8) pg = 0;
                end
            endcase
            case ($urandom_range(0, 3))
                0: off = 12'h0F0;
                1: off = 12'h000;
                2: off = $urandom_range(4092, 4095);
                default: off = $urandom_range(0, 4095);
            endcase
            a = {4'(pg), 12'(off)};
            inst = inst_of(a);
            for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_read(a, d, 1'b0, inst, -1, -1, "rnd");
            else
                do_write(a, d, inst, -1, "rnd");
        end

        tb_en = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
